// File: rtl/flash_pkg.sv
// Shared constants and types for the SPI flash operation scheduler.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package flash_pkg;

   // M25P16 command opcodes
   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_SE   = 8'hD8;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_RDSR = 8'h05;

   // client index == bit position in req/gnt/done
   localparam logic [1:0] CL_SE = 2'd0;
   localparam logic [1:0] CL_PP = 2'd1;
   localparam logic [1:0] CL_RD = 2'd2;

   typedef enum logic [2:0] {IDLE, WREN, GAP1, CMD, GAP2, POLL, FIN} state_t;

   // sub-phase of one chip-select frame: cs setup, byte shifting, cs hold
   typedef enum logic [1:0] {PH_SETUP, PH_SHIFT, PH_HOLD} phase_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/spi_byte_io.sv
// SPI mode-0 byte shifter: one byte out on mosi (MSB first) and one in from miso.
// Latency: 16*SCK_DIV cycles per byte; byte_done is high in the cycle of the last sck fall.
// Backpressure: none; a start in the byte_done cycle chains the next byte with no sck gap.
// Ports: start/tx_byte load a byte; rx_byte holds the received byte (complete at byte_done);
//        sck idles low, mosi is 0 while idle; miso sampled on the sck rising edge.
module spi_byte_io #(
   parameter int SCK_DIV = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic       sck,
   output logic       mosi,
   output logic [7:0] rx_byte,
   output logic       byte_done
);
   import flash_pkg::*;

   localparam int            DW       = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);

   logic          running;
   logic [DW-1:0] div_cnt;
   logic [3:0]    phase;     // even phases end in a rise, odd phases in a fall
   logic [7:0]    tx_sr;
   logic          tick;

   assign tick      = running && (div_cnt == DIV_LAST);
   // combinational so the scheduler can chain the next byte on the same edge
   assign byte_done = tick && (phase == 4'd15);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         running <= 1'b0;
         div_cnt <= '0;
         phase   <= '0;
         tx_sr   <= '0;
         rx_byte <= '0;
         sck     <= 1'b0;
         mosi    <= 1'b0;
      end else if (start && (!running || byte_done)) begin
         // MSB goes out now, ahead of the first rise of this byte
         running <= 1'b1;
         div_cnt <= '0;
         phase   <= '0;
         tx_sr   <= {tx_byte[6:0], 1'b0};
         mosi    <= tx_byte[7];
         sck     <= 1'b0;
      end else if (tick) begin
         div_cnt <= '0;
         phase   <= phase + 4'd1;
         sck     <= ~sck;
         if (!sck) begin
            rx_byte <= {rx_byte[6:0], miso};
         end else if (phase == 4'd15) begin
            running <= 1'b0;
            mosi    <= 1'b0;
         end else begin
            mosi  <= tx_sr[7];
            tx_sr <= {tx_sr[6:0], 1'b0};
         end
      end else if (running) begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

endmodule

// File: rtl/flash_op_sched.sv
// Round-robin scheduler/sequencer for erase, page-program and read on one SPI flash port.
// Latency: gnt one cycle after a sampled req in IDLE; done after the full WREN/CMD/RDSR sequence.
// Backpressure: requests are level-held and wait while busy; one operation in flight at a time.
// Ports: req[2:0] (erase/program/read) with their address/data; gnt/done one-hot pulses,
//        err with done on poll timeout, rd_data from the read op, busy gnt..done;
//        cs_n/sck/mosi/miso to the flash pins.
module flash_op_sched #(
   parameter int          SCK_DIV  = 2,
   parameter int          CS_GAP   = 32,
   parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [2:0]  req,
   input  logic [23:0] se_addr,
   input  logic [23:0] pp_addr,
   input  logic [7:0]  pp_data,
   input  logic [23:0] rd_addr,
   output logic [2:0]  gnt,
   output logic [2:0]  done,
   output logic        err,
   output logic [7:0]  rd_data,
   output logic        busy,
   output logic        cs_n,
   output logic        sck,
   output logic        mosi,
   input  logic        miso
);
   import flash_pkg::*;

   localparam logic [15:0] SETUP_LAST = 16'(SCK_DIV - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(2 * SCK_DIV - 1);
   localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);

   state_t      state;
   phase_t      ph;
   logic [15:0] cnt;        // setup / hold / gap counter
   logic [2:0]  byte_idx;   // byte currently shifting within the frame
   logic [15:0] poll_cnt;   // status bytes completed in POLL
   logic        timeout_q;
   logic [1:0]  client;
   logic [1:0]  rr_ptr;
   logic [23:0] addr_q;
   logic [7:0]  data_q;
   logic [7:0]  op_q;

   logic        grant_vld;
   logic [1:0]  grant_idx;
   logic [2:0]  cand;
   logic        more;
   logic        poll_last;
   logic        start;
   logic [2:0]  tx_sel;
   logic [7:0]  tx_byte;
   logic [7:0]  rx_byte;
   logic        byte_done;

   // Round-robin: scan offsets 2..0 so the smallest offset from rr_ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = CL_SE;
      cand      = '0;
      for (int i = 2; i >= 0; i--) begin
         cand = {1'b0, rr_ptr} + 3'(i);
         if (cand >= 3'd3) cand = cand - 3'd3;
         if (req[cand[1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[1:0];
         end
      end
   end

   assign poll_last = ({1'b0, poll_cnt} + 17'd1) >= {1'b0, POLL_MAX};

   // Whether another byte follows the one completing now in this frame.
   always_comb begin
      more = 1'b0;
      case (state)
         CMD:     more = byte_idx < ((client == CL_SE) ? 3'd3 : 3'd4);
         POLL:    more = (byte_idx == 3'd0) || (rx_byte[0] && !poll_last);
         default: more = 1'b0;
      endcase
   end

   assign start = (state inside {WREN, CMD, POLL}) &&
                  (((ph == PH_SETUP) && (cnt == SETUP_LAST)) ||
                   ((ph == PH_SHIFT) && byte_done && more));

   assign tx_sel = (ph == PH_SETUP) ? 3'd0 : byte_idx + 3'd1;

   always_comb begin
      tx_byte = 8'h00;
      case (state)
         WREN: tx_byte = OP_WREN;
         CMD: begin
            case (tx_sel)
               3'd0:    tx_byte = op_q;
               3'd1:    tx_byte = addr_q[23:16];
               3'd2:    tx_byte = addr_q[15:8];
               3'd3:    tx_byte = addr_q[7:0];
               default: tx_byte = data_q;   // 0x00 dummy for read
            endcase
         end
         POLL:    tx_byte = (ph == PH_SETUP) ? OP_RDSR : 8'h00;
         default: tx_byte = 8'h00;
      endcase
   end

   spi_byte_io #(.SCK_DIV(SCK_DIV)) u_io (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .start     (start),
      .tx_byte   (tx_byte),
      .miso      (miso),
      .sck       (sck),
      .mosi      (mosi),
      .rx_byte   (rx_byte),
      .byte_done (byte_done)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= IDLE;
         ph        <= PH_SETUP;
         cnt       <= '0;
         byte_idx  <= '0;
         poll_cnt  <= '0;
         timeout_q <= 1'b0;
         client    <= CL_SE;
         rr_ptr    <= CL_SE;
         addr_q    <= '0;
         data_q    <= '0;
         op_q      <= '0;
         gnt       <= '0;
         done      <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
         rd_data   <= '0;
         cs_n      <= 1'b1;
      end else begin
         gnt  <= '0;
         done <= '0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  gnt       <= 3'b001 << grant_idx;
                  busy      <= 1'b1;
                  client    <= grant_idx;
                  rr_ptr    <= (grant_idx == CL_RD) ? CL_SE : grant_idx + 2'd1;
                  cs_n      <= 1'b0;
                  ph        <= PH_SETUP;
                  cnt       <= '0;
                  timeout_q <= 1'b0;
                  case (grant_idx)
                     CL_PP: begin
                        addr_q <= pp_addr; data_q <= pp_data; op_q <= OP_PP;   state <= WREN;
                     end
                     CL_RD: begin
                        addr_q <= rd_addr; data_q <= 8'h00;   op_q <= OP_READ; state <= CMD;
                     end
                     default: begin
                        addr_q <= se_addr; data_q <= 8'h00;   op_q <= OP_SE;   state <= WREN;
                     end
                  endcase
               end
            end
            GAP1, GAP2: begin
               if (cnt == GAP_LAST) begin
                  cs_n     <= 1'b0;
                  ph       <= PH_SETUP;
                  cnt      <= '0;
                  poll_cnt <= '0;
                  state    <= (state == GAP1) ? CMD : POLL;
               end else begin
                  cnt <= sat_inc16(cnt);
               end
            end
            WREN, CMD, POLL: begin
               case (ph)
                  PH_SETUP: begin
                     if (cnt == SETUP_LAST) begin
                        ph       <= PH_SHIFT;
                        byte_idx <= '0;
                     end else begin
                        cnt <= sat_inc16(cnt);
                     end
                  end
                  PH_SHIFT: begin
                     if (byte_done) begin
                        // byte 0 of POLL is the RDSR opcode, later ones are status
                        if ((state == POLL) && (byte_idx != 3'd0)) begin
                           poll_cnt <= sat_inc16(poll_cnt);
                           if (rx_byte[0] && poll_last) timeout_q <= 1'b1;
                        end
                        if (start) begin
                           byte_idx <= (byte_idx == 3'd7) ? byte_idx : byte_idx + 3'd1;
                        end else begin
                           ph  <= PH_HOLD;
                           cnt <= '0;
                        end
                     end
                  end
                  PH_HOLD: begin
                     if (cnt == HOLD_LAST) begin
                        cs_n <= 1'b1;
                        cnt  <= '0;
                        ph   <= PH_SETUP;
                        if (state == WREN) begin
                           state <= GAP1;
                        end else if ((state == CMD) && (client != CL_RD)) begin
                           state <= GAP2;
                        end else begin
                           state <= FIN;
                           done  <= 3'b001 << client;
                           err   <= timeout_q;
                           if (client == CL_RD) rd_data <= rx_byte;
                        end
                     end else begin
                        cnt <= sat_inc16(cnt);
                     end
                  end
                  default: ph <= PH_SETUP;
               endcase
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_op_sched.sv
// Bench for flash_op_sched: bus monitor + flash model, scoreboard of expected command frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_flash_op_sched;

   localparam int          SCK_DIV  = 2;
   localparam int          CS_GAP   = 32;
   localparam logic [15:0] POLL_MAX = 16'd4;
   localparam int          EDGE     = 2 * SCK_DIV;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [2:0]  req     = '0;
   logic [23:0] se_addr = '0;
   logic [23:0] pp_addr = '0;
   logic [7:0]  pp_data = '0;
   logic [23:0] rd_addr = '0;
   logic [2:0]  gnt, done;
   logic        err, busy, cs_n, sck, mosi;
   logic [7:0]  rd_data;
   logic        miso = 1'b0;

   flash_op_sched #(.SCK_DIV(SCK_DIV), .CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
      .sys_clk (sys_clk), .sys_rst (sys_rst), .req (req),
      .se_addr (se_addr), .pp_addr (pp_addr), .pp_data (pp_data), .rd_addr (rd_addr),
      .gnt (gnt), .done (done), .err (err), .rd_data (rd_data), .busy (busy),
      .cs_n (cs_n), .sck (sck), .mosi (mosi), .miso (miso)
   );

   always #5 sys_clk = ~sys_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- bus monitor and flash model ----------------
   typedef struct packed {
      logic [7:0][7:0] b;
      logic [31:0]     rises;
      logic [31:0]     setup;
      logic [31:0]     hold;
      logic [31:0]     gap;
      logic            bad;
   } cmd_t;

   cmd_t        cur;
   cmd_t        log_q[$];
   int          cyc = 0, last_cs_rise = 0, cs_fall = 0, last_rise = 0, last_fall = 0;
   int          rises = 0, stat_idx = 0, k = 0, idle_viol = 0, done_seen = 0;
   int unsigned r;
   logic        prev_cs = 1'b1, prev_sck = 1'b0;
   logic [7:0]  shreg = '0, stat = '0;
   int          cfg_wip = 0;      // status bytes reporting WIP=1 before it clears
   logic [7:0]  cfg_rd = '0;      // byte the flash returns on READ

   always @(posedge sys_clk) begin
      #1;
      cyc++;
      if (prev_cs && !cs_n) begin
         cur = '0;
         cur.gap = cyc - last_cs_rise;
         cs_fall = cyc;
         rises = 0;
         stat_idx = 0;
      end
      if (!prev_sck && sck) begin
         if (rises == 0) cur.setup = cyc - cs_fall;
         else if (cyc - last_rise != EDGE) cur.bad = 1'b1;
         last_rise = cyc;
         shreg = {shreg[6:0], mosi};
         rises++;
         if ((rises % 8 == 0) && (rises <= 64)) cur.b[rises/8 - 1] = shreg;
      end
      if (prev_sck && !sck) begin
         last_fall = cyc;
         if ((rises >= 8) && (cur.b[0] == 8'h05)) begin
            k = (rises - 8) % 8;
            if (k == 0) begin
               r = $urandom;
               stat = {r[6:0], (stat_idx < cfg_wip) ? 1'b1 : 1'b0};
               stat_idx++;
            end
            miso = stat[7-k];
         end else if ((rises >= 32) && (rises < 40) && (cur.b[0] == 8'h03)) begin
            miso = cfg_rd[7-(rises-32)];
         end
      end
      if (!prev_cs && cs_n) begin
         cur.hold = cyc - last_fall;
         cur.rises = rises;
         log_q.push_back(cur);
         last_cs_rise = cyc;
      end
      if (cs_n && (sck || mosi)) idle_viol++;
      if (done != 3'b000) done_seen++;
      prev_cs = cs_n;
      prev_sck = sck;
   end

   // ---------------- reference model / scoreboard ----------------
   int          rr_last = 2;     // last granted client; search resumes at rr_last+1
   logic [7:0]  last_rd = '0;
   logic [23:0] p_addr[3];
   logic [7:0]  p_data = '0;
   logic [7:0]  p_rd   = '0;
   int          p_wip[3];

   task automatic raise(input int cl, input logic [23:0] a, input logic [7:0] d,
                        input int wip, input logic [7:0] rv);
      p_addr[cl] = a;
      p_wip[cl]  = wip;
      if (cl == 0) se_addr = a;
      if (cl == 1) begin pp_addr = a; pp_data = d; p_data = d; end
      if (cl == 2) begin rd_addr = a; p_rd = rv; end
      req[cl] = 1'b1;
   endtask

   task automatic serve();
      int cl, base, n_exp, nb, ncmp, nstat;
      bit got;
      bit exp_err;
      logic [7:0] eb[5];
      cmd_t c;
      cl = -1;
      for (int i = 1; i <= 3; i++) begin
         if (cl < 0 && req[(rr_last + i) % 3]) cl = (rr_last + i) % 3;
      end
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(posedge sys_clk); #1;
         if (gnt != 3'b000) got = 1;
      end
      if (!got) begin check_eq("gnt_wait", 0, 1); return; end
      check_eq("gnt", gnt, 32'(3'b001 << cl));
      check_eq("busy_at_gnt", busy, 1);
      rr_last = cl;
      req[cl] = 1'b0;
      cfg_wip = p_wip[cl];
      cfg_rd  = p_rd;
      base    = log_q.size();
      nstat   = (p_wip[cl] + 1 < int'(POLL_MAX)) ? p_wip[cl] + 1 : int'(POLL_MAX);
      exp_err = (cl != 2) && (p_wip[cl] >= int'(POLL_MAX));
      if (cl == 2) last_rd = p_rd;

      got = 0;
      for (int t = 0; t < 4000 && !got; t++) begin
         @(posedge sys_clk); #1;
         if (done != 3'b000) got = 1;
      end
      if (!got) begin check_eq("done_wait", 0, 1); return; end
      check_eq($sformatf("done_cl%0d", cl), done, 32'(3'b001 << cl));
      check_eq($sformatf("err_cl%0d", cl), err, exp_err);
      check_eq("rd_data", rd_data, last_rd);
      check_eq("busy_at_done", busy, 1);
      @(posedge sys_clk); #1;
      check_eq("done_pulse_end", done, 0);
      check_eq("busy_after_done", busy, 0);

      n_exp = (cl == 2) ? 1 : 3;
      check_eq($sformatf("ncmd_cl%0d", cl), log_q.size() - base, n_exp);
      if (log_q.size() - base == n_exp) begin
         for (int i = 0; i < n_exp; i++) begin
            c = log_q[base + i];
            eb = '{8'h00, p_addr[cl][23:16], p_addr[cl][15:8], p_addr[cl][7:0], p_data};
            if (cl == 2) begin
               eb[0] = 8'h03; nb = 5; ncmp = 4;
            end else if (i == 0) begin
               eb[0] = 8'h06; nb = 1; ncmp = 1;
            end else if (i == 1) begin
               eb[0] = (cl == 0) ? 8'hD8 : 8'h02;
               nb = (cl == 0) ? 4 : 5; ncmp = nb;
            end else begin
               eb[0] = 8'h05; nb = 1 + nstat; ncmp = 1;
            end
            check_eq($sformatf("rises_cl%0d_cmd%0d", cl, i), c.rises, nb * 8);
            for (int j = 0; j < ncmp; j++)
               check_eq($sformatf("byte_cl%0d_cmd%0d_b%0d", cl, i, j), c.b[j], eb[j]);
            check_eq($sformatf("setup_cl%0d_cmd%0d", cl, i), c.setup, EDGE);
            check_eq($sformatf("hold_cl%0d_cmd%0d", cl, i), c.hold, EDGE);
            check_eq($sformatf("sck_period_cl%0d_cmd%0d", cl, i), c.bad, 0);
            if (i > 0) check_eq($sformatf("gap_cl%0d_cmd%0d", cl, i), c.gap, CS_GAP);
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int d0;
      bit got;
      p_addr = '{default: '0};
      p_wip  = '{default: 0};
      repeat (3) @(posedge sys_clk);
      #1;
      check_eq("rst_cs_n", cs_n, 1);
      check_eq("rst_sck", sck, 0);
      check_eq("rst_mosi", mosi, 0);
      check_eq("rst_gnt", gnt, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rd_data", rd_data, 0);
      sys_rst = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;

      // erase with three busy status bytes, program clearing at once, read
      raise(0, 24'h000425, 8'h00, 3, 8'h00); serve();
      raise(1, 24'h000200, 8'h3C, 0, 8'h00); serve();
      raise(2, 24'h000100, 8'h00, 0, 8'hA5); serve();

      // all three held: 001, 010, 100; then 011 raised again -> 001 first
      raise(0, 24'h0A0000, 8'h00, 1, 8'h00);
      raise(1, 24'h0B1234, 8'h99, 2, 8'h00);
      raise(2, 24'h0C5678, 8'h00, 0, 8'h5E);
      serve(); serve(); serve();
      raise(0, 24'h1F0000, 8'h00, 0, 8'h00);
      raise(1, 24'h1F00FF, 8'h81, 0, 8'h00);
      serve(); serve();

      // WIP stuck high -> POLL_MAX status bytes and err; exactly POLL_MAX busy bytes too
      raise(0, 24'h0F0F0F, 8'h00, 1000, 8'h00); serve();
      raise(1, 24'h00F000, 8'h42, int'(POLL_MAX), 8'h00); serve();

      // reset in the middle of the read address bytes
      raise(2, 24'h123456, 8'h00, 0, 8'h77);
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(posedge sys_clk); #1;
         if (gnt != 3'b000) got = 1;
      end
      check_eq("rst_mid_gnt", gnt, 3'b100);
      req[2] = 1'b0;
      repeat (50) @(posedge sys_clk);
      #1 sys_rst = 1'b1;
      @(posedge sys_clk);
      #1;
      check_eq("rst_mid_cs_n", cs_n, 1);
      check_eq("rst_mid_sck", sck, 0);
      check_eq("rst_mid_busy", busy, 0);
      check_eq("rst_mid_rd_data", rd_data, 0);
      sys_rst = 1'b0;
      rr_last = 2;
      last_rd = '0;
      d0 = done_seen;
      repeat (200) @(posedge sys_clk);
      #1;
      check_eq("rst_mid_no_done", done_seen - d0, 0);
      raise(0, 24'h0000AA, 8'h00, 2, 8'h00); serve();

      // random traffic with overlapping held requests
      for (int it = 0; it < 25; it++) begin
         for (int c = 0; c < 3; c++)
            if (!req[c] && ($urandom % 2 == 1))
               raise(c, 24'($urandom), 8'($urandom), int'($urandom % 6), 8'($urandom));
         if (req == 3'b000)
            raise(int'($urandom % 3), 24'($urandom), 8'($urandom), int'($urandom % 6), 8'($urandom));
         serve();
      end
      for (int n = 0; n < 3 && req != 3'b000; n++) serve();

      check_eq("idle_bus_quiet", idle_viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/flash_op_sched.md
Name: flash_op_sched

Overview:
- Scheduler and sequencer for the single SPI flash port (M25P16-class, SPI mode 0).
- Three clients share the bus: sector-erase, page-program (one byte) and read (one byte). A round-robin arbiter picks one client at a time.
- For the granted client the block issues the full command sequence: write-enable, opcode, address, data, then status polling until the flash is no longer busy.
- It replaces per-operation controllers that each drove cs_n/sck/mosi directly. It sits between the key/UART-driven client logic and the flash pins.

Parameters:
SCK_DIV, 2, sys_clk cycles per SCK half-period (one byte = 16*SCK_DIV cycles = 32 at default)
CS_GAP, 32, sys_clk cycles cs_n held high between chained commands (WREN->op, op->RDSR)
POLL_MAX, 16'hFFFF, maximum status bytes read in the polling phase before timeout

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  synchronous active-high reset
req  in  3  request per client: [0] erase, [1] program, [2] read; each bit level-held until its gnt
se_addr  in  24  erase sector address
pp_addr  in  24  program address
pp_data  in  8  program data byte
rd_addr  in  24  read address
gnt  out  3  one-hot, 1-cycle pulse when a request is accepted; addr/data captured on that cycle
done  out  3  one-hot, 1-cycle pulse when the granted operation completes
err  out  1  1-cycle pulse coincident with done when polling timed out
rd_data  out  8  byte returned by the read op; valid from the done[2] cycle until the next read done
busy  out  1  high from the gnt cycle through the done cycle
cs_n  out  1  flash chip select, active low
sck  out  1  SPI clock, idles low
mosi  out  1  SPI data to flash, MSB first
miso  in  1  SPI data from flash

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-high on sys_rst; it is sampled on the sys_clk rising edge.
- Reset values: cs_n=1, sck=0, mosi=0, gnt=0, done=0, err=0, busy=0, rd_data=0, rr_ptr=0, state=IDLE.
- Reset mid-operation: the cycle after sys_rst is sampled, cs_n=1 and sck=0. There is no completion pulse for the aborted operation.
- Arbitration:
  - Sampled only in IDLE.
  - Round-robin over req, starting from rr_ptr (0=erase, 1=program, 2=read); rr_ptr becomes granted+1 mod 3.
  - The gnt pulse and the capture of address, data and opcode occur in the same cycle.
  - Requests raised while busy wait; a request dropped before its grant is ignored.
- Opcodes: WREN 0x06, SE 0xD8, PP 0x02, READ 0x03, RDSR 0x05.
- States: IDLE, WREN, GAP1, CMD, GAP2, POLL, FIN.
- IDLE -> WREN on grant of erase or program; IDLE -> CMD on grant of read.
- WREN: cs_n low, one byte 0x06, cs_n high, then -> GAP1.
- GAP1: CS_GAP cycles with cs_n high, then -> CMD.
- CMD:
  - cs_n low, then the opcode followed by addr[23:16], addr[15:8], addr[7:0].
  - Program op: then pp_data.
  - Read op: then one received byte, captured into rd_data.
  - Then cs_n high.
  - Read op -> FIN; otherwise -> GAP2.
- GAP2: CS_GAP cycles, then -> POLL.
- POLL:
  - cs_n low, send RDSR, then read status bytes back-to-back with cs_n held low.
  - After each status byte: if bit0 (WIP)=0, cs_n high and -> FIN.
  - If POLL_MAX status bytes are read with WIP still 1: cs_n high, err pulse, -> FIN.
- FIN: one cycle, done[client]=1; busy falls the next cycle; -> IDLE. A new grant is possible one cycle after FIN.
- Byte timing:
  - cs_n falls 2*SCK_DIV cycles before the first sck rise.
  - mosi updates at each sck fall (and ahead of the first rise); miso is sampled at sck rise.
  - cs_n rises 2*SCK_DIV cycles after the last sck fall of a command.
  - sck is 0 whenever cs_n=1.
  - Bytes within one command are contiguous, with no sck gap.
- mosi=0 while not shifting.
- Counters: the gap counter and poll counter saturate; the poll counter is 16-bit and cleared on POLL entry.

Decomposition:
- Shared package flash_pkg: opcode constants, client index constants (CL_SE=0, CL_PP=1, CL_RD=2), state encoding.
- One sub-module, spi_byte_io: start/tx_byte in, rx_byte/byte_done out, generates sck/mosi and samples miso at SCK_DIV. The scheduler owns cs_n and sequencing.

Test Plan:
1. Erase only: req=3'b001, se_addr=24'h000425, flash model WIP=1 for 3 status bytes -> gnt=001; bus shows 0x06, gap >=32 cycles, D8 00 04 25, gap, 05 + 4 status bytes; done=001, err=0.
2. Read: rd_addr=24'h000100, model returns 0xA5 -> 03 00 01 00 then 8 sck rises, rd_data=8'hA5 at done=100, no WREN on bus.
3. Program: pp_addr=24'h000200, pp_data=8'h3C, WIP clears on first status byte -> 06 / 02 00 02 00 3C / 05 + 1 status byte, done=010.
4. Round-robin: req=3'b111 held -> grant order 001, 010, 100; re-raised req=3'b011 after read -> next grant 001.
5. Timeout: POLL_MAX=4, WIP stuck at 1 -> exactly 4 status bytes, cs_n high, done=001 and err=1 in the same cycle.
6. Reset mid-CMD: assert sys_rst during the address byte -> next cycle cs_n=1, sck=0, busy=0; no done pulse; a later request sequences normally.
